// File: rtl/cordic_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_arbiter
//
// Purpose:
//   Lets NUM_REQ requesters share one pipelined CORDIC core. The core has no
//   backpressure and a fixed en->ready latency of LATENCY cycles. At most one
//   request is granted per cycle and registered into the core's input side.
//   The requester ID of every issued op travels through a latency-matched tag
//   pipe, so each core result goes back to the requester that asked for it.
//
// Configuration macro:
//   CORDIC_ARB_FIXED_PRIO_EN - when defined, the grant is fixed priority with
//   the lowest index winning, and the round-robin pointer is removed. When
//   undefined (default), the grant is round-robin starting at rr_ptr.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   arb_en              grant enable; low stops new grants only
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_mode            packed 2-bit modes, requester i at [2i+1:2i]
//   req_x/req_y/req_z   packed IN_WIDTH operands, requester i at slice i
//   core_en, core_mode, core_x/y/z   registered issue to the core
//   core_ready, core_r, core_a       core result side
//   rsp_valid           one-hot result strobe (registered)
//   rsp_r, rsp_a, rsp_id  result data and originating requester
//   busy                an op is in flight (core_en high or tag pipe non-empty)
//   err                 sticky: core_ready and the last tag stage disagreed
// ---------------------------------------------------------------------------
module cordic_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int LATENCY   = 20,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [2*NUM_REQ-1:0]          req_mode,
  input  logic [IN_WIDTH*NUM_REQ-1:0]   req_x,
  input  logic [IN_WIDTH*NUM_REQ-1:0]   req_y,
  input  logic [IN_WIDTH*NUM_REQ-1:0]   req_z,
  output logic                          core_en,
  output logic [1:0]                    core_mode,
  output logic [IN_WIDTH-1:0]           core_x,
  output logic [IN_WIDTH-1:0]           core_y,
  output logic [IN_WIDTH-1:0]           core_z,
  input  logic                          core_ready,
  input  logic [OUT_WIDTH-1:0]          core_r,
  input  logic [OUT_WIDTH-1:0]          core_a,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [OUT_WIDTH-1:0]          rsp_r,
  output logic [OUT_WIDTH-1:0]          rsp_a,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy,
  output logic                          err
);

  // Grant result: whether someone is selected this cycle and who.
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic            transfer;

  // Operand fields of the selected requester.
  logic [1:0]          sel_mode;
  logic [IN_WIDTH-1:0] sel_x;
  logic [IN_WIDTH-1:0] sel_y;
  logic [IN_WIDTH-1:0] sel_z;

  // ID of the op currently presented to the core.
  logic [ID_W-1:0] issue_id;

  // Tag pipe: one {valid,id} pair per core pipeline stage.
  logic [LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [LATENCY];

  logic               tag_last_valid;
  logic [ID_W-1:0]    tag_last_id;
  logic [NUM_REQ-1:0] tag_last_onehot;

`ifdef CORDIC_ARB_FIXED_PRIO_EN

  // Fixed priority: scan downward so the lowest valid index is the last
  // one written and therefore wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    if (!arb_en) begin
      grant_found = 1'b0;
    end
  end

`else

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] rr_ptr;

  // Round-robin: walk from rr_ptr upward, wrapping at NUM_REQ, and take the
  // first valid requester. The sum is one bit wider so the wrap test is exact
  // for non-power-of-two NUM_REQ.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      idx = sum[ID_W-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
    if (!arb_en) begin
      grant_found = 1'b0;
    end
  end

  // The pointer moves just past the winner, so a requester that keeps its
  // valid high waits for every other valid requester before winning again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

`endif

  // req_ready is also gated by rst_n so nothing looks accepted while the
  // block is held in reset.
  assign transfer = grant_found & rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (transfer && (grant_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Operand mux, written as a compare loop so every slice index is constant.
  always_comb begin
    sel_mode = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_z    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_mode = req_mode[2*i +: 2];
        sel_x    = req_x[IN_WIDTH*i +: IN_WIDTH];
        sel_y    = req_y[IN_WIDTH*i +: IN_WIDTH];
        sel_z    = req_z[IN_WIDTH*i +: IN_WIDTH];
      end
    end
  end

  // Issue stage: core_en pulses the cycle after a transfer. The operand
  // registers only load on a transfer, so they hold between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_en   <= 1'b0;
      core_mode <= '0;
      core_x    <= '0;
      core_y    <= '0;
      core_z    <= '0;
      issue_id  <= '0;
    end else begin
      core_en <= transfer;
      if (transfer) begin
        core_mode <= sel_mode;
        core_x    <= sel_x;
        core_y    <= sel_y;
        core_z    <= sel_z;
        issue_id  <= grant_id;
      end
    end
  end

  // Tag pipe: stage 0 samples core_en in the same edge the core samples it,
  // so the valid bit reaches the last stage exactly when core_ready rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_valid[0] <= core_en;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign tag_last_valid = tag_valid[LATENCY-1];
  assign tag_last_id    = tag_id[LATENCY-1];

  always_comb begin
    tag_last_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_last_id == ID_W'(i)) begin
        tag_last_onehot[i] = 1'b1;
      end
    end
  end

  // Response stage: a result is forwarded only when the core and the tag
  // pipe agree. A lone core_ready or a lone tag produces no strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_r     <= '0;
      rsp_a     <= '0;
      rsp_id    <= '0;
    end else if (core_ready && tag_last_valid) begin
      rsp_valid <= tag_last_onehot;
      rsp_r     <= core_r;
      rsp_a     <= core_a;
      rsp_id    <= tag_last_id;
    end else begin
      rsp_valid <= '0;
    end
  end

  // Any disagreement between core_ready and the last tag means the LATENCY
  // parameter does not match the core; remember it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (core_ready != tag_last_valid) begin
      err <= 1'b1;
    end
  end

  assign busy = core_en | (|tag_valid);

endmodule
